// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs instruction requests into MIPS words and writes them to consecutive
// instruction-memory addresses. Define ENCODER_CHECK_EN to reject unsupported R-type funct codes.
module instr_encoder_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_kind_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [5:0]        funct_i,
    input  logic [15:0]       imm_i,
    input  logic [25:0]       target_i,
    output logic              im_we_o,
    output logic [ADDR_W-1:0] im_addr_o,
    output logic [31:0]       im_wdata_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              err_o
);
    typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;

    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

    state_t            state_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] naddr_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W:0]   count_q;
    logic              err_q;
    logic [5:0]        op;
    logic [31:0]       word;
    logic              acc;
    logic              bad;
    logic              wr;

    // opcode lookup and field packing for the three instruction formats
    always_comb begin
        op   = req_kind_i == 3'd0 ? 6'b000000 :
               req_kind_i == 3'd1 ? 6'b001101 :
               req_kind_i == 3'd2 ? 6'b001001 :
               req_kind_i == 3'd3 ? 6'b100011 :
               req_kind_i == 3'd4 ? 6'b101011 :
               req_kind_i == 3'd5 ? 6'b000100 :
               req_kind_i == 3'd6 ? 6'b000101 : 6'b000010;
        word = req_kind_i == 3'd0 ? {op, rs_i, rt_i, rd_i, 5'd0, funct_i} :
               req_kind_i == 3'd7 ? {op, target_i} : {op, rs_i, rt_i, imm_i};
    end

    assign req_ready_o = (state_q == RUN) && !start_i;
    assign acc         = req_valid_i && req_ready_o;
`ifdef ENCODER_CHECK_EN
    assign bad = (req_kind_i == 3'd0) &&
                 !(funct_i inside {6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010});
`else
    assign bad = 1'b0;
`endif
    assign wr  = acc && !bad;

    // session control, write pipeline stage and counters; start restarts the session at address 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            naddr_q <= '0;
            wdata_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            we_q <= wr;
            if (wr) begin
                addr_q  <= naddr_q;
                wdata_q <= word;
            end
            if (start_i) begin
                state_q <= RUN;
                naddr_q <= '0;
                count_q <= '0;
                err_q   <= 1'b0;
            end else if (wr) begin
                naddr_q <= naddr_q + 1'b1;
                count_q <= count_q + 1'b1;
                if (count_q == LAST) state_q <= FULL;
            end else if (acc) begin
                err_q <= 1'b1;
            end
        end
    end

    assign im_we_o    = we_q;
    assign im_addr_o  = addr_q;
    assign im_wdata_o = wdata_q;
    assign count_o    = count_q;
    assign full_o     = state_q == FULL;
    assign err_o      = err_q;
endmodule
